// File: rtl/mem_arbiter.sv
// Arbitrates the shared SRAM between the fetch and data ports.
// Round-robin grant, fixed-latency access, registered completion pulses.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_done,
  output logic                inst_stall,
  input  logic                data_req,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_done,
  output logic                data_stall,
  output logic                mem_cs,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int SW = DATA_W / 8;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              last_dat_q;
  logic              gnt_dat_q;
  logic              mem_cs_q;
  logic [SW-1:0]     mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] inst_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;
  logic              inst_done_q;
  logic              data_done_q;
  logic              pick_dat;

  // Data wins a tie unless it was the last port served.
  assign pick_dat = data_req & (~inst_req | ~last_dat_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_dat_q   <= 1'b0;
      gnt_dat_q    <= 1'b0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (inst_req | data_req) begin
            gnt_dat_q   <= pick_dat;
            last_dat_q  <= pick_dat;
            mem_cs_q    <= 1'b1;
            mem_addr_q  <= pick_dat ? data_addr : inst_addr;
            mem_we_q    <= pick_dat ? data_we : '0;
            mem_wdata_q <= pick_dat ? data_wdata : '0;
            cnt_q       <= CNT_INIT;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            if (gnt_dat_q) begin
              if (mem_we_q == '0) begin
                data_rdata_q <= mem_rdata;
              end
              data_done_q <= 1'b1;
            end else begin
              inst_rdata_q <= mem_rdata;
              inst_done_q  <= 1'b1;
            end
            mem_cs_q <= 1'b0;
            mem_we_q <= '0;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          inst_done_q <= 1'b0;
          data_done_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_cs     = mem_cs_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_done  = inst_done_q;
  assign data_done  = data_done_q;
  assign inst_stall = inst_req & ~inst_done_q;
  assign data_stall = data_req & ~data_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-schedule model, SRAM model,
// directed latency cases and a randomized two-port run.
module tb_mem_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [15:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        inst_stall;
  logic        data_req = 1'b0;
  logic [15:0] data_addr = '0;
  logic [3:0]  data_we = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        data_stall;
  logic        mem_cs;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_done(inst_done),
    .inst_stall(inst_stall),
    .data_req(data_req), .data_addr(data_addr),
    .data_we(data_we), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_done(data_done),
    .data_stall(data_stall),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // SRAM: data valid only in the last cs cycle, write commits at its end
  logic [31:0] sram [0:16383];
  logic [31:0] mmem [0:16383];
  int cs_cnt = 0;

  assign mem_rdata = (mem_cs && cs_cnt == L - 1) ?
                     sram[mem_addr[15:2]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (!mem_cs) begin
      cs_cnt <= 0;
    end else begin
      if (cs_cnt == L - 1) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b])
            sram[mem_addr[15:2]][8*b+:8] = mem_wdata[8*b+:8];
      end
      cs_cnt <= cs_cnt + 1;
    end
  end

  // Two extra builds at the latency extremes
  logic        sreq [2];
  logic [15:0] saddr [2];
  logic [31:0] s_irdata [2];
  logic [31:0] s_drdata [2];
  logic        s_idone [2];
  logic        s_ddone [2];
  logic        s_istall [2];
  logic        s_dstall [2];
  logic        s_cs [2];
  logic [3:0]  s_mwe [2];
  logic [15:0] s_maddr [2];
  logic [31:0] s_mwdata [2];
  logic [31:0] s_mrdata [2];
  logic        zero1 = 1'b0;
  logic [15:0] zero16 = '0;
  logic [3:0]  zero4 = '0;
  logic [31:0] zero32 = '0;

  assign s_mrdata[0] = s_cs[0] ? {16'hC0DE, s_maddr[0]} : 32'h0;
  assign s_mrdata[1] = s_cs[1] ? {16'hC0DE, s_maddr[1]} : 32'h0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .inst_req(sreq[0]), .inst_addr(saddr[0]),
    .inst_rdata(s_irdata[0]), .inst_done(s_idone[0]),
    .inst_stall(s_istall[0]),
    .data_req(zero1), .data_addr(zero16),
    .data_we(zero4), .data_wdata(zero32),
    .data_rdata(s_drdata[0]), .data_done(s_ddone[0]),
    .data_stall(s_dstall[0]),
    .mem_cs(s_cs[0]), .mem_we(s_mwe[0]), .mem_addr(s_maddr[0]),
    .mem_wdata(s_mwdata[0]), .mem_rdata(s_mrdata[0])
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(15)) dut_l15 (
    .clk(clk), .rst(rst),
    .inst_req(sreq[1]), .inst_addr(saddr[1]),
    .inst_rdata(s_irdata[1]), .inst_done(s_idone[1]),
    .inst_stall(s_istall[1]),
    .data_req(zero1), .data_addr(zero16),
    .data_we(zero4), .data_wdata(zero32),
    .data_rdata(s_drdata[1]), .data_done(s_ddone[1]),
    .data_stall(s_dstall[1]),
    .mem_cs(s_cs[1]), .mem_we(s_mwe[1]), .mem_addr(s_maddr[1]),
    .mem_wdata(s_mwdata[1]), .mem_rdata(s_mrdata[1])
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle)", tag, got, exp);
    end
  endtask

  // Transaction-schedule model: one access at a time, each taking
  // L cs cycles then a done cycle, next grant no earlier than after.
  int          k = 0;
  int          g = 0;
  int          free = 0;
  bit          act = 0;
  bit          gd = 0;
  bit          last_d = 0;
  logic [15:0] ea;
  logic [3:0]  ewe;
  logic [31:0] ewd;
  logic [31:0] pend;
  logic [31:0] cur_ir = '0;
  logic [31:0] cur_dr = '0;
  logic [13:0] undo_i;
  logic [31:0] undo_v;
  bit          seen_i = 0;
  bit          seen_d = 0;

  task automatic check_model();
    bit ecs, eid, edd;
    ecs = act && (k > g) && (k <= g + L);
    eid = act && !gd && (k == g + L + 1);
    edd = act && gd && (k == g + L + 1);
    if (eid) cur_ir = pend;
    if (edd && ewe == 4'h0) cur_dr = pend;
    chk("mem_cs", mem_cs, ecs);
    chk("mem_we", mem_we, ecs ? ewe : 4'h0);
    if (ecs) begin
      chk("mem_addr", mem_addr, ea);
      if (ewe != 4'h0) chk("mem_wdata", mem_wdata, ewd);
    end
    chk("inst_done", inst_done, eid);
    chk("data_done", data_done, edd);
    chk("one_done", inst_done & data_done, 0);
    chk("inst_stall", inst_stall, inst_req & ~eid);
    chk("data_stall", data_stall, data_req & ~edd);
    chk("inst_rdata", inst_rdata, cur_ir);
    chk("data_rdata", data_rdata, cur_dr);
    seen_i = inst_done;
    seen_d = data_done;
    if (eid || edd) begin
      act = 0;
      free = k + 1;
    end
    if (!act && k >= free && (inst_req || data_req)) begin
      gd = data_req && (!inst_req || !last_d);
      last_d = gd;
      act = 1;
      g = k;
      if (gd) begin
        ea = data_addr; ewe = data_we; ewd = data_wdata;
      end else begin
        ea = inst_addr; ewe = 4'h0; ewd = '0;
      end
      undo_i = ea[15:2];
      undo_v = mmem[undo_i];
      pend = mmem[undo_i];
      for (int b = 0; b < 4; b++)
        if (ewe[b]) mmem[undo_i][8*b+:8] = ewd[8*b+:8];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    inst_req = 0; data_req = 0; sreq[0] = 0; sreq[1] = 0;
    #1 rst = 0;
    #1;
    chk("rst_cs", mem_cs, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_irdata", inst_rdata, 0);
    chk("rst_drdata", data_rdata, 0);
    chk("rst_idone", inst_done, 0);
    chk("rst_ddone", data_done, 0);
    if (act) mmem[undo_i] = undo_v;
    act = 0; last_d = 0; cur_ir = '0; cur_dr = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1;
    k++;
    free = k;
  endtask

  task automatic wait_done(input bit d, output int dc);
    dc = -1;
    for (int n = 0; n < 60 && dc < 0; n++) begin
      tick();
      if (d ? seen_d : seen_i) dc = k - 1;
    end
    if (dc < 0) chk(d ? "timeout_d" : "timeout_i", 0, 1);
    if (d) data_req = 0;
    else inst_req = 0;
  endtask

  task automatic new_inst();
    inst_req = 1;
    inst_addr = 16'(($urandom % 16) * 4);
  endtask

  task automatic new_data();
    data_req = 1;
    data_addr = (($urandom % 2) != 0 ? 16'h8000 : 16'h0000) |
                16'(($urandom % 16) * 4);
    data_we = (($urandom % 2) != 0) ? 4'h0 : 4'($urandom % 16);
    data_wdata = $urandom;
  endtask

  task automatic lat_test(input int j, input int lat);
    int dc = -1;
    int ncs = 0;
    logic [31:0] rd = '0;
    sreq[j] = 1;
    saddr[j] = 16'h0100 + 16'(j * 4);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_cs[j]) ncs++;
      if (s_idone[j] && dc < 0) begin
        dc = c;
        rd = s_irdata[j];
      end
      @(posedge clk);
      #1;
      k++;
      if (dc >= 0) sreq[j] = 0;
    end
    chk("lat_done", dc, lat + 1);
    chk("lat_cs", ncs, lat);
    chk("lat_data", rd, {16'hC0DE, saddr[j]});
  endtask

  initial begin
    int t0, dd, di, nd;
    bit seq[$];
    for (int i = 0; i < 16384; i++) begin
      logic [31:0] v;
      v = $urandom;
      sram[i] = v;
      mmem[i] = v;
    end
    sram[14'h2000] = 32'hA0B0C0D0;
    mmem[14'h2000] = 32'hA0B0C0D0;
    sram[1] = 32'hDEADBEEF;
    mmem[1] = 32'hDEADBEEF;
    do_reset();

    // write aborted by reset in its last cs cycle
    data_req = 1; data_addr = 16'h8000;
    data_we = 4'hF; data_wdata = 32'h55667788;
    tick();
    tick();
    chk("mid_cs", mem_cs, 1);
    do_reset();
    repeat (6) tick();
    chk("rst_nowrite", sram[14'h2000], 32'hA0B0C0D0);

    // single fetch
    inst_req = 1; inst_addr = 16'h0004;
    t0 = k;
    wait_done(0, di);
    chk("fetch_lat", di - t0, L + 1);
    chk("fetch_data", inst_rdata, 32'hDEADBEEF);

    // partial write then read back
    data_req = 1; data_addr = 16'h8000;
    data_we = 4'b0011; data_wdata = 32'h11223344;
    t0 = k;
    wait_done(1, dd);
    chk("wr_lat", dd - t0, L + 1);
    chk("wr_sram", sram[14'h2000], 32'hA0B03344);
    tick();
    data_req = 1; data_we = 4'h0;
    wait_done(1, dd);
    chk("rd_merge", data_rdata, 32'hA0B03344);

    // simultaneous requests right after reset
    do_reset();
    inst_req = 1; inst_addr = 16'h0004;
    data_req = 1; data_addr = 16'h8000; data_we = 4'h0;
    t0 = k;
    wait_done(1, dd);
    wait_done(0, di);
    chk("sim_d_lat", dd - t0, L + 1);
    chk("sim_i_lat", di - t0, 2 * L + 3);

    // both ports saturated
    do_reset();
    new_inst();
    new_data();
    nd = 0;
    for (int n = 0; n < 200 && nd < 8; n++) begin
      tick();
      if (seen_d) begin seq.push_back(1'b1); nd++; new_data(); end
      if (seen_i) begin seq.push_back(1'b0); nd++; new_inst(); end
    end
    chk("cont_cnt", seq.size(), 8);
    foreach (seq[i]) chk("cont_order", seq[i], (i % 2) == 0);
    inst_req = 0; data_req = 0;
    repeat (8) tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      tick();
      if (seen_i) inst_req = 0;
      if (seen_d) data_req = 0;
      if (!inst_req && ($urandom % 3) == 0) new_inst();
      if (!data_req && ($urandom % 3) == 0) new_data();
    end
    inst_req = 0; data_req = 0;
    repeat (10) tick();

    lat_test(0, 1);
    lat_test(1, 15);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
